// File: rtl/cpu_nic.sv
// Memory-mapped NIC between the processor memory stage and a mesh router local port.
// Optional CPU_NIC_IRQ_EN adds a registered irq output flagging a non-empty input FIFO.
module cpu_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di
`ifdef CPU_NIC_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [0:DATA_WIDTH-1] out_mem [DEPTH];
  logic [0:DATA_WIDTH-1] in_mem  [DEPTH];

  logic [PTR_W-1:0] out_wr_ptr_reg, out_rd_ptr_reg;
  logic [PTR_W-1:0] in_wr_ptr_reg, in_rd_ptr_reg;
  logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;
  logic [CNT_W-1:0] in_cnt_reg, in_cnt_next;

  logic out_full, out_empty, in_empty;
  logic out_push, out_pop, in_push, in_pop;
  logic rd_en;
  logic [0:DATA_WIDTH-1] out_head, in_head;
  logic [0:DATA_WIDTH-1] in_status, out_status, rd_data;

  assign out_full  = (out_cnt_reg == FULL_CNT);
  assign out_empty = (out_cnt_reg == '0);
  assign in_empty  = (in_cnt_reg == '0);
  assign out_head  = out_mem[out_rd_ptr_reg];
  assign in_head   = in_mem[in_rd_ptr_reg];

  // Router side: head bit 0 selects the virtual-channel phase it may leave in.
  assign net_so = !out_empty && net_ro && (out_head[0] == net_polarity);
  assign net_do = out_head;
  assign net_ri = (in_cnt_reg != FULL_CNT);

  assign rd_en    = nicEn && !nicWrEn;
  assign out_pop  = net_so;
  assign in_pop   = rd_en && (addr == 2'b00) && !in_empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign out_push = nicEn && nicWrEn && (addr == 2'b10) && (!out_full || out_pop);
  assign in_push  = net_si && (net_ri || in_pop);

  always_comb begin
    out_cnt_next = out_cnt_reg;
    case ({out_push, out_pop})
      2'b10:   out_cnt_next = out_cnt_reg + CNT_W'(1);
      2'b01:   out_cnt_next = out_cnt_reg - CNT_W'(1);
      default: out_cnt_next = out_cnt_reg;
    endcase
  end

  always_comb begin
    in_cnt_next = in_cnt_reg;
    case ({in_push, in_pop})
      2'b10:   in_cnt_next = in_cnt_reg + CNT_W'(1);
      2'b01:   in_cnt_next = in_cnt_reg - CNT_W'(1);
      default: in_cnt_next = in_cnt_reg;
    endcase
  end

  // Status words: flag in the last bit, count just above it, rest zero.
  always_comb begin
    in_status  = '0;
    out_status = '0;
    in_status[DATA_WIDTH-1]                      = !in_empty;
    in_status[DATA_WIDTH-1-CNT_W : DATA_WIDTH-2] = in_cnt_reg;
    out_status[DATA_WIDTH-1]                      = out_full;
    out_status[DATA_WIDTH-1-CNT_W : DATA_WIDTH-2] = out_cnt_reg;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      2'b00:   rd_data = in_empty ? '0 : in_head;
      2'b01:   rd_data = in_status;
      2'b11:   rd_data = out_status;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr_ptr_reg] <= d_in;
    if (in_push)  in_mem[in_wr_ptr_reg]   <= net_di;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
      out_cnt_reg    <= '0;
      in_wr_ptr_reg  <= '0;
      in_rd_ptr_reg  <= '0;
      in_cnt_reg     <= '0;
      d_out          <= '0;
    end else begin
      if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + PTR_W'(1);
      if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + PTR_W'(1);
      if (in_push)  in_wr_ptr_reg  <= in_wr_ptr_reg + PTR_W'(1);
      if (in_pop)   in_rd_ptr_reg  <= in_rd_ptr_reg + PTR_W'(1);
      out_cnt_reg <= out_cnt_next;
      in_cnt_reg  <= in_cnt_next;
      if (rd_en) d_out <= rd_data;
    end
  end

`ifdef CPU_NIC_IRQ_EN
  // Follows input occupancy one cycle late.
  always_ff @(posedge clk) begin
    if (!reset) irq <= 1'b0;
    else        irq <= !in_empty;
  end
`endif

endmodule

// File: tb/tb_cpu_nic.sv
// Self-checking bench for cpu_nic: directed vector table followed by random traffic,
// both checked against a queue-based reference model.
module tb_cpu_nic;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, nicEn, nicWrEn, net_so, net_ro, net_polarity, net_si, net_ri;
  logic [1:0]    addr;
  logic [0:DW-1] d_in, d_out, net_do, net_di;

  cpu_nic #(.DATA_WIDTH(64), .DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .addr(addr), .nicEn(nicEn), .nicWrEn(nicWrEn),
    .d_in(d_in), .d_out(d_out), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity), .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
  );

  typedef struct {
    logic rst, en, wr;
    logic [1:0] a;
    logic [0:DW-1] din;
    logic ro, pol, si;
    logic [0:DW-1] di;
    logic so, ri;
    logic [0:DW-1] dox, dout;
  } vec_t;

  vec_t tab[$];
  vec_t none;
  logic [0:DW-1] oq[$];
  logic [0:DW-1] iq[$];
  logic [0:DW-1] exp_dout;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [0:DW-1] act, input logic [0:DW-1] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Status word as a number: count times two plus the flag in the last bit.
  function automatic logic [0:DW-1] status(input int cnt, input bit flag);
    logic [0:DW-1] r;
    r = DW'(cnt * 2 + (flag ? 1 : 0));
    return r;
  endfunction

  function automatic vec_t mk(input logic rst, en, wr, input logic [1:0] a, input logic [0:DW-1] din,
                              input logic ro, pol, si, input logic [0:DW-1] di,
                              input logic so, ri, input logic [0:DW-1] dox, dout);
    vec_t v;
    v.rst = rst; v.en = en; v.wr = wr; v.a = a; v.din = din;
    v.ro = ro; v.pol = pol; v.si = si; v.di = di;
    v.so = so; v.ri = ri; v.dox = dox; v.dout = dout;
    return v;
  endfunction

  // One clock: check combinational outputs, cross the edge, advance the model, check d_out.
  task automatic tick(input bit use_tab, input vec_t v);
    bit eso, eri, rd, pop_in;
    int osz, isz;
    logic [0:DW-1] nd;
    #2;
    osz = oq.size();
    isz = iq.size();
    eso = 1'b0;
    if (osz != 0) eso = net_ro && (oq[0][0] == net_polarity);
    eri = (isz != 2);
    chk("net_so", net_so, eso);
    chk("net_ri", net_ri, eri);
    if (eso) chk("net_do", net_do, oq[0]);
    if (use_tab) begin
      chk("tab_net_so", net_so, v.so);
      chk("tab_net_ri", net_ri, v.ri);
      if (v.so) chk("tab_net_do", net_do, v.dox);
    end
    rd = nicEn && !nicWrEn;
    nd = exp_dout;
    if (rd) begin
      case (addr)
        2'd0: nd = (isz != 0) ? iq[0] : '0;
        2'd1: nd = status(isz, isz != 0);
        2'd2: nd = '0;
        default: nd = status(osz, osz == 2);
      endcase
    end
    pop_in = rd && (addr == 2'd0) && (isz != 0);
    @(posedge clk);
    #1;
    if (!reset) begin
      oq.delete();
      iq.delete();
      exp_dout = '0;
    end else begin
      if (eso) void'(oq.pop_front());
      if (nicEn && nicWrEn && addr == 2'd2 && (osz < 2 || eso)) oq.push_back(d_in);
      if (pop_in) void'(iq.pop_front());
      if (net_si && (isz < 2 || pop_in)) iq.push_back(net_di);
      exp_dout = nd;
    end
    chk("d_out", d_out, exp_dout);
    if (use_tab) chk("tab_d_out", d_out, v.dout);
  endtask

  initial begin
    logic [0:DW-1] aa, ff, p1;
    aa = 64'hAAAA_AAAA_AAAA_AAAA;
    ff = 64'h5555_5555_5555_5555;
    p1 = 64'h8000_0000_0000_0001;
    //           rst en wr a  din            ro pol si di      so ri do       dout
    tab.push_back(mk(1, 1, 0, 1, 0,             0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 0, 3, 0,             0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 1, 2, 64'hDEADBEEF,  1, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 0, 0, 0, 0,             1, 0, 0, 0,     1, 1, 64'hDEADBEEF, 0));
    tab.push_back(mk(1, 1, 0, 3, 0,             1, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 1, 2, p1,            1, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 0, 0, 0, 0,             1, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 0, 0, 0, 0,             1, 1, 0, 0,     1, 1, p1,      0));
    tab.push_back(mk(1, 1, 0, 3, 0,             1, 1, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 1, 2, 64'h11,        0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 1, 2, 64'h22,        0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 1, 2, 64'h33,        0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 0, 3, 0,             0, 0, 0, 0,     0, 1, 0,       5));
    tab.push_back(mk(1, 0, 0, 0, 0,             1, 0, 0, 0,     1, 1, 64'h11,  5));
    tab.push_back(mk(1, 0, 0, 0, 0,             1, 0, 0, 0,     1, 1, 64'h22,  5));
    tab.push_back(mk(1, 0, 0, 0, 0,             1, 0, 0, 0,     0, 1, 0,       5));
    tab.push_back(mk(1, 0, 0, 0, 0,             0, 0, 1, aa,    0, 1, 0,       5));
    tab.push_back(mk(1, 0, 0, 0, 0,             0, 0, 1, ff,    0, 1, 0,       5));
    tab.push_back(mk(1, 0, 0, 0, 0,             0, 0, 0, 0,     0, 0, 0,       5));
    tab.push_back(mk(1, 1, 0, 0, 0,             0, 0, 0, 0,     0, 0, 0,       aa));
    tab.push_back(mk(1, 1, 0, 0, 0,             0, 0, 0, 0,     0, 1, 0,       ff));
    tab.push_back(mk(1, 1, 0, 0, 0,             0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 0, 0, 0, 0,             0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 0, 0, 0, 0,             0, 0, 1, 64'hA, 0, 1, 0,       0));
    tab.push_back(mk(1, 0, 0, 0, 0,             0, 0, 1, 64'hB, 0, 1, 0,       0));
    tab.push_back(mk(1, 1, 0, 0, 0,             0, 0, 1, 64'hC, 0, 0, 0,       64'hA));
    tab.push_back(mk(1, 1, 0, 1, 0,             0, 0, 0, 0,     0, 0, 0,       5));
    tab.push_back(mk(1, 1, 0, 0, 0,             0, 0, 0, 0,     0, 0, 0,       64'hB));
    tab.push_back(mk(1, 1, 0, 0, 0,             0, 0, 0, 0,     0, 1, 0,       64'hC));
    tab.push_back(mk(1, 1, 0, 1, 0,             0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 1, 2, 64'h44,        0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 1, 2, 64'h55,        0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 1, 2, 64'h66,        1, 0, 0, 0,     1, 1, 64'h44,  0));
    tab.push_back(mk(1, 1, 0, 3, 0,             0, 0, 0, 0,     0, 1, 0,       5));
    tab.push_back(mk(1, 0, 0, 0, 0,             1, 0, 0, 0,     1, 1, 64'h55,  5));
    tab.push_back(mk(1, 0, 0, 0, 0,             1, 0, 0, 0,     1, 1, 64'h66,  5));
    tab.push_back(mk(1, 1, 0, 3, 0,             1, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 1, 2, 64'h77,        0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 0, 3, 0,             0, 0, 1, 64'h99, 0, 1, 0,      2));
    tab.push_back(mk(0, 0, 0, 0, 0,             0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 0, 0, 0,             0, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 0, 3, 0,             1, 0, 0, 0,     0, 1, 0,       0));
    tab.push_back(mk(1, 1, 0, 1, 0,             0, 0, 0, 0,     0, 1, 0,       0));

    reset = 1'b0; addr = 2'd0; nicEn = 1'b0; nicWrEn = 1'b0; d_in = '0;
    net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_d_out", d_out, '0);
    chk("reset_net_so", net_so, 1'b0);
    chk("reset_net_ri", net_ri, 1'b1);
    exp_dout = '0;
    reset = 1'b1;

    foreach (tab[i]) begin
      reset = tab[i].rst; nicEn = tab[i].en; nicWrEn = tab[i].wr; addr = tab[i].a;
      d_in = tab[i].din; net_ro = tab[i].ro; net_polarity = tab[i].pol;
      net_si = tab[i].si; net_di = tab[i].di;
      tick(1'b1, tab[i]);
    end

    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(60) != 0);
      nicEn        = ($urandom_range(3) != 0);
      nicWrEn      = $urandom_range(1);
      addr         = 2'($urandom_range(3));
      d_in         = {$urandom, $urandom};
      net_ro       = ($urandom_range(9) < 6);
      net_polarity = $urandom_range(1);
      net_si       = $urandom_range(1);
      net_di       = {$urandom, $urandom};
      tick(1'b0, none);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
